// File: rtl/sysid_chk_pkg.sv
// Shared constants for the system-ID checker: FSM encoding, default expected
// words and the two word addresses of the sysid slave.
package sysid_chk_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RD_ID_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_ID_WAIT = 3'd2;
  localparam logic [2:0] ST_RD_TS_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_TS_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_RD_ID_REQ  = ST_RD_ID_REQ,
    S_RD_ID_WAIT = ST_RD_ID_WAIT,
    S_RD_TS_REQ  = ST_RD_TS_REQ,
    S_RD_TS_WAIT = ST_RD_TS_WAIT,
    S_DONE       = ST_DONE
  } state_t;

  localparam logic [31:0] SYSID_EXPECTED_ID = 32'd0;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1521037506;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_chk_timer.sv
// Per-access watchdog counter. terminal flags the cycle whose increment makes
// the count reach LIMIT.
module sysid_chk_timer #(
  parameter int LIMIT = 255,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// reports whether they match the build-time expected values.
module first_nios2_system_sysid_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [2:0]  fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          launch;
  logic          id_hit;
  logic          ts_hit;
  logic          id_accept;
  logic          ts_accept;
  logic          tmr_clear;
  logic          tmr_terminal;
  logic [TW-1:0] tmr_count;

  // Handshake: a request is accepted in a cycle with read=1 and waitrequest=0;
  // data is taken on readdatavalid, either in that same cycle or in the WAIT state.
  always_comb begin
    launch    = 1'b0;
    id_hit    = 1'b0;
    ts_hit    = 1'b0;
    id_accept = 1'b0;
    ts_accept = 1'b0;
    case (state)
      S_IDLE, S_DONE: launch = start;
      S_RD_ID_REQ: begin
        id_accept = !avm_waitrequest;
        id_hit    = !avm_waitrequest && avm_readdatavalid;
      end
      S_RD_ID_WAIT: id_hit = avm_readdatavalid;
      S_RD_TS_REQ: begin
        ts_accept = !avm_waitrequest;
        ts_hit    = !avm_waitrequest && avm_readdatavalid;
      end
      S_RD_TS_WAIT: ts_hit = avm_readdatavalid;
      default: ;
    endcase
    tmr_clear = launch || id_hit;
  end

  sysid_chk_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (tmr_clear),
    .enable   (busy),
    .count    (tmr_count),
    .terminal (tmr_terminal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else if (launch) begin
      state       <= S_RD_ID_REQ;
      avm_read    <= 1'b1;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else if (id_hit) begin
      // An ID mismatch is only recorded; the timestamp read still follows.
      captured_id <= avm_readdata;
      id_mismatch <= (avm_readdata != EXPECTED_ID);
      state       <= S_RD_TS_REQ;
      avm_read    <= 1'b1;
      avm_address <= SYSID_ADDR_TS;
    end else if (ts_hit) begin
      captured_ts <= avm_readdata;
      ts_mismatch <= (avm_readdata != EXPECTED_TS);
      pass        <= !id_mismatch && (avm_readdata == EXPECTED_TS);
      state       <= S_DONE;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b1;
    end else if (tmr_terminal) begin
      // Watchdog abandons the stalled access outright.
      timeout     <= 1'b1;
      pass        <= 1'b0;
      state       <= S_DONE;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b1;
    end else if (id_accept) begin
      state    <= S_RD_ID_WAIT;
      avm_read <= 1'b0;
    end else if (ts_accept) begin
      state    <= S_RD_TS_WAIT;
      avm_read <= 1'b0;
    end
  end

  assign fsm_state = state;

endmodule
